time_entry_loader: RTL and testbench
====================================

Name: time_entry_loader

Overview:
- Keypad-side writer for the microwave countdown timer chain, which is built from per-digit down-counters (mod-10 ones, mod-6 tens).
- Collects up to 4 keyed decimal digits as MM:SS, validates them, and presents them on parallel load buses.
- Issues the single-cycle active-low load strobe and drives the chain count-enable.
- Tracks run, pause and done until the chain reports all-zero.

Parameters:
- SEC_TENS_MAX, 5, largest legal seconds-tens digit; start with a larger value is rejected.
- KEY_W, 4, width of key code and of each digit bus.

Ports:
- clk  in  1  system clock, all state on rising edge.
- clrn  in  1  asynchronous, active-high reset.
- key_valid  in  1  one-cycle strobe; key_code is valid.
- key_code  in  KEY_W  BCD digit 0-9; codes 10-15 are ignored.
- start  in  1  one-cycle start/resume request.
- stop_clear  in  1  one-cycle stop (pause) / clear request.
- timer_zero  in  1  high while the whole timer chain reads 00:00.
- min_tens, min_ones, sec_tens, sec_ones  out  KEY_W each  digit buses to the chain data inputs.
- loadn  out  1  active-low load strobe, low for exactly 1 cycle.
- en  out  1  count enable to the chain.
- running  out  1  high in RUN.
- done  out  1  one-cycle pulse when the countdown reaches zero.
- err  out  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset (clrn=1, asynchronous):
  - state=IDLE; all digits=0; digit count=0.
  - loadn=1; en=0; running=0; done=0; err=0.
- States: IDLE, ENTRY, LOAD, RUN, PAUSE, DONE.
- Same-cycle input priority: clrn > stop_clear > start > key_valid.
- Key entry (IDLE or ENTRY only, key_code<=9):
  - Shift left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_code.
  - Count increments; state goes to ENTRY.
  - When count=4, further keys are ignored with no shift.
  - Keys in LOAD/RUN/PAUSE/DONE and codes >9 are ignored.
- start in IDLE/ENTRY:
  - All digits 0 -> ignored, state unchanged.
  - sec_tens > SEC_TENS_MAX -> err=1 for 1 cycle; digits cleared; count=0; state goes to IDLE.
  - Otherwise -> LOAD.
- LOAD:
  - loadn=0 for exactly 1 cycle with digits stable on the buses; en=0.
  - Next state RUN unconditionally.
- RUN:
  - en=1, running=1.
  - timer_zero is ignored in the first RUN cycle after LOAD, because the chain is still settling.
  - From the second RUN cycle on, timer_zero=1 -> DONE.
  - stop_clear -> PAUSE.
  - start is ignored.
- PAUSE:
  - en=0, running=0; digit registers are held (the chain retains its live count).
  - start -> RUN with no reload and no settle guard.
  - stop_clear -> IDLE, clearing digits and count.
- DONE: done=1 for 1 cycle; digits cleared; count=0; next state IDLE.
- stop_clear in IDLE/ENTRY: clears digits and count; state goes to IDLE.
- stop_clear in LOAD: ignored; the load completes first.
- Simultaneous timer_zero and stop_clear in RUN: stop_clear wins -> PAUSE.
  - A later start resumes into RUN, which sees timer_zero and goes to DONE next cycle.
- Outputs loadn, en, running, done and err are registered (Moore), with no combinational path from inputs.
- Reset mid-operation (any state): immediate return to the reset values above; en drops asynchronously.

Test Plan:
1. Reset, then keys 1,3,0 and start -> digits 0,1,3,0; loadn low exactly 1 cycle; en=1 from the next cycle; running=1.
2. Keys 1,2,3,4,5 -> 5th key ignored, digits 1,2,3,4; key_code=11 mid-sequence -> no shift, count unchanged.
3. Keys 0,7,5 (sec_tens=7) then start -> err 1-cycle pulse, digits 0000, state IDLE, loadn stays 1.
4. Start with no keys entered -> no loadn, no err, state IDLE.
5. Run 00:02; in RUN: stop_clear -> en=0, running=0; start -> en=1 with no loadn; timer_zero=1 -> done 1-cycle pulse, en=0, digits cleared.
6. timer_zero held high through LOAD and the first RUN cycle -> no DONE until the second RUN cycle.
7. clrn pulsed asynchronously mid-RUN -> all outputs at reset values before the next clk edge.
8. stop_clear and start in the same cycle in ENTRY -> clear wins; IDLE, digits 0, no loadn.

Source files
------------

// File: rtl/time_entry_loader.sv
// time_entry_loader: keypad-side writer for the microwave countdown chain.
// Collects up to four BCD digits as MM:SS and checks the seconds-tens digit.
// Presents the digits on parallel load buses and strobes loadn for one cycle.
// Then gates the chain count-enable through run / pause until the chain reads zero.
module time_entry_loader #(
  parameter int SEC_TENS_MAX = 5,
  parameter int KEY_W        = 4
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_code,
  input  logic             start,
  input  logic             stop_clear,
  input  logic             timer_zero,
  output logic [KEY_W-1:0] min_tens,
  output logic [KEY_W-1:0] min_ones,
  output logic [KEY_W-1:0] sec_tens,
  output logic [KEY_W-1:0] sec_ones,
  output logic             loadn,
  output logic             en,
  output logic             running,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    LOAD,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t     state;
  logic [2:0] count;
  logic       settle;

  logic       key_ok;
  logic       all_zero;
  logic       tens_bad;
  logic       room;

  // Decode the keypad and the current digit registers for the FSM below.
  always_comb begin
    key_ok   = key_valid && (key_code <= KEY_W'(9));
    all_zero = (min_tens == '0) && (min_ones == '0) &&
               (sec_tens == '0) && (sec_ones == '0);
    tens_bad = (sec_tens > KEY_W'(SEC_TENS_MAX));
    room     = (count != 3'd4);
  end

  // Single FSM: the state, digit shift register and every registered output.
  // done/err default low each cycle so they can only ever pulse for one cycle.
  // settle marks the first RUN cycle after a load, when the chain is still
  // settling and its zero flag cannot be trusted.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state    <= IDLE;
      count    <= 3'd0;
      settle   <= 1'b0;
      min_tens <= '0;
      min_ones <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
      loadn    <= 1'b1;
      en       <= 1'b0;
      running  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE, ENTRY: begin
          if (stop_clear) begin
            min_tens <= '0;
            min_ones <= '0;
            sec_tens <= '0;
            sec_ones <= '0;
            count    <= 3'd0;
            state    <= IDLE;
          end else if (start) begin
            if (all_zero) begin
              state <= state;
            end else if (tens_bad) begin
              err      <= 1'b1;
              min_tens <= '0;
              min_ones <= '0;
              sec_tens <= '0;
              sec_ones <= '0;
              count    <= 3'd0;
              state    <= IDLE;
            end else begin
              loadn <= 1'b0;
              state <= LOAD;
            end
          end else if (key_ok) begin
            if (room) begin
              min_tens <= min_ones;
              min_ones <= sec_tens;
              sec_tens <= sec_ones;
              sec_ones <= key_code;
              count    <= count + 3'd1;
            end
            state <= ENTRY;
          end
        end

        LOAD: begin
          loadn   <= 1'b1;
          en      <= 1'b1;
          running <= 1'b1;
          settle  <= 1'b1;
          state   <= RUN;
        end

        RUN: begin
          settle <= 1'b0;
          if (stop_clear) begin
            en      <= 1'b0;
            running <= 1'b0;
            state   <= PAUSE;
          end else if (timer_zero && !settle) begin
            en       <= 1'b0;
            running  <= 1'b0;
            done     <= 1'b1;
            min_tens <= '0;
            min_ones <= '0;
            sec_tens <= '0;
            sec_ones <= '0;
            count    <= 3'd0;
            state    <= DONE;
          end
        end

        PAUSE: begin
          if (stop_clear) begin
            min_tens <= '0;
            min_ones <= '0;
            sec_tens <= '0;
            sec_ones <= '0;
            count    <= 3'd0;
            state    <= IDLE;
          end else if (start) begin
            en      <= 1'b1;
            running <= 1'b1;
            settle  <= 1'b0;
            state   <= RUN;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          loadn   <= 1'b1;
          en      <= 1'b0;
          running <= 1'b0;
          settle  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_entry_loader.sv
// tb_time_entry_loader: directed scenarios plus a randomized run checked
// against a value-level model of the keypad timer loader.
module tb_time_entry_loader;

  localparam int SEC_MAX = 5;

  logic       clk;
  logic       clrn;
  logic       key_valid;
  logic [3:0] key_code;
  logic       start;
  logic       stop_clear;
  logic       timer_zero;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       loadn, en, running, done, err;

  int checks = 0;
  int fails  = 0;

  time_entry_loader #(.SEC_TENS_MAX(SEC_MAX), .KEY_W(4)) dut (
    .clk(clk), .clrn(clrn), .key_valid(key_valid), .key_code(key_code),
    .start(start), .stop_clear(stop_clear), .timer_zero(timer_zero),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
    .sec_ones(sec_ones), .loadn(loadn), .en(en), .running(running),
    .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the entered time is a plain integer MMSS value.
  typedef enum {M_IDLE, M_ENTRY, M_LOAD, M_RUN, M_PAUSE, M_DONE} mode_t;
  mode_t m_mode;
  int    m_value;
  int    m_count;
  int    m_run_age;
  bit    m_err;

  task automatic model_reset();
    m_mode = M_IDLE; m_value = 0; m_count = 0; m_run_age = 0; m_err = 0;
  endtask

  task automatic model_step(input logic kv, input logic [3:0] kc,
                            input logic st, input logic sc, input logic tz);
    m_err = 0;
    case (m_mode)
      M_IDLE, M_ENTRY: begin
        if (sc) begin
          m_value = 0; m_count = 0; m_mode = M_IDLE;
        end else if (st) begin
          if (m_value == 0) begin
            m_mode = m_mode;
          end else if ((m_value / 10) % 10 > SEC_MAX) begin
            m_err = 1; m_value = 0; m_count = 0; m_mode = M_IDLE;
          end else begin
            m_mode = M_LOAD;
          end
        end else if (kv && kc <= 9) begin
          if (m_count < 4) begin
            m_value = (m_value * 10 + int'(kc)) % 10000;
            m_count++;
          end
          m_mode = M_ENTRY;
        end
      end
      M_LOAD: begin
        m_mode = M_RUN; m_run_age = 0;
      end
      M_RUN: begin
        if (sc) m_mode = M_PAUSE;
        else if (tz && m_run_age > 0) begin
          m_mode = M_DONE; m_value = 0; m_count = 0;
        end else m_run_age++;
      end
      M_PAUSE: begin
        if (sc) begin
          m_value = 0; m_count = 0; m_mode = M_IDLE;
        end else if (st) begin
          m_mode = M_RUN; m_run_age = 1;
        end
      end
      M_DONE: m_mode = M_IDLE;
      default: m_mode = M_IDLE;
    endcase
  endtask

  function automatic logic [20:0] model_vec();
    logic [15:0] d;
    d = {4'(m_value / 1000), 4'((m_value / 100) % 10),
         4'((m_value / 10) % 10), 4'(m_value % 10)};
    return {d, (m_mode != M_LOAD), (m_mode == M_RUN), (m_mode == M_RUN),
            (m_mode == M_DONE), m_err};
  endfunction

  function automatic logic [15:0] dut_digits();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  function automatic logic [20:0] dut_vec();
    return {min_tens, min_ones, sec_tens, sec_ones, loadn, en, running, done, err};
  endfunction

  // One clock: drive inputs, advance model at the edge, settle 1 time unit.
  task automatic tick(input logic kv, input logic [3:0] kc,
                      input logic st, input logic sc, input logic tz);
    key_valid = kv; key_code = kc; start = st; stop_clear = sc; timer_zero = tz;
    @(posedge clk);
    model_step(kv, kc, st, sc, tz);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    tick(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    clrn = 1'b1;
    key_valid = 0; key_code = 0; start = 0; stop_clear = 0; timer_zero = 0;
    #2;
    checks++;
    if (dut_vec() !== {16'h0000, 5'b10000}) begin
      fails++; $display("[TB] FAIL reset_outputs: got %h, expected %h", dut_vec(), {16'h0000, 5'b10000});
    end
    @(posedge clk); #1;
    clrn = 1'b0;
    model_reset();
  endtask

  task automatic test_entry_and_load();
    key(4'd1); key(4'd3); key(4'd0);
    checks++;
    if (dut_digits() !== 16'h0130) begin
      fails++; $display("[TB] FAIL entry_digits: got %h, expected 0130", dut_digits());
    end
    tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({loadn, en, running} !== 3'b000 || dut_digits() !== 16'h0130) begin
      fails++; $display("[TB] FAIL load_strobe: got %b/%h, expected 000/0130", {loadn, en, running}, dut_digits());
    end
    idle();
    checks++;
    if ({loadn, en, running} !== 3'b111) begin
      fails++; $display("[TB] FAIL run_after_load: got %b, expected 111", {loadn, en, running});
    end
    idle();
    checks++;
    if ({loadn, en, running} !== 3'b111) begin
      fails++; $display("[TB] FAIL loadn_single_cycle: got %b, expected 111", {loadn, en, running});
    end
    tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (dut_digits() !== 16'h0000 || en !== 1'b0) begin
      fails++; $display("[TB] FAIL clear_from_pause: got %h en=%b, expected 0000 en=0", dut_digits(), en);
    end
  endtask

  task automatic test_key_limit();
    key(4'd1); key(4'd2); key(4'd11);
    checks++;
    if (dut_digits() !== 16'h0012) begin
      fails++; $display("[TB] FAIL invalid_code_ignored: got %h, expected 0012", dut_digits());
    end
    key(4'd3); key(4'd4); key(4'd5);
    checks++;
    if (dut_digits() !== 16'h1234) begin
      fails++; $display("[TB] FAIL fifth_key_ignored: got %h, expected 1234", dut_digits());
    end
    tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (dut_digits() !== 16'h0000) begin
      fails++; $display("[TB] FAIL clear_in_entry: got %h, expected 0000", dut_digits());
    end
  endtask

  task automatic test_bad_secs();
    key(4'd0); key(4'd7); key(4'd5);
    tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({loadn, err} !== 2'b11 || dut_digits() !== 16'h0000) begin
      fails++; $display("[TB] FAIL reject_err: got loadn,err=%b digits=%h, expected 11/0000", {loadn, err}, dut_digits());
    end
    idle();
    checks++;
    if ({loadn, err, en} !== 3'b100) begin
      fails++; $display("[TB] FAIL err_single_cycle: got %b, expected 100", {loadn, err, en});
    end
    key(4'd4);
    checks++;
    if (dut_digits() !== 16'h0004) begin
      fails++; $display("[TB] FAIL entry_after_reject: got %h, expected 0004", dut_digits());
    end
    tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_empty_start();
    tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({loadn, en, err} !== 3'b100) begin
      fails++; $display("[TB] FAIL empty_start_ignored: got %b, expected 100", {loadn, en, err});
    end
    idle();
    checks++;
    if ({loadn, en, err} !== 3'b100) begin
      fails++; $display("[TB] FAIL empty_start_no_load: got %b, expected 100", {loadn, en, err});
    end
  endtask

  task automatic test_pause_resume();
    key(4'd2);
    tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(); idle();
    tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({en, running, loadn} !== 3'b001 || dut_digits() !== 16'h0002) begin
      fails++; $display("[TB] FAIL pause_outputs: got %b/%h, expected 001/0002", {en, running, loadn}, dut_digits());
    end
    tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({en, running, loadn} !== 3'b111) begin
      fails++; $display("[TB] FAIL resume_no_reload: got %b, expected 111", {en, running, loadn});
    end
    tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({done, en, running} !== 3'b100 || dut_digits() !== 16'h0000) begin
      fails++; $display("[TB] FAIL done_pulse: got %b/%h, expected 100/0000", {done, en, running}, dut_digits());
    end
    idle();
    checks++;
    if (done !== 1'b0) begin
      fails++; $display("[TB] FAIL done_single_cycle: got %b, expected 0", done);
    end
  endtask

  task automatic test_settle_guard();
    key(4'd5);
    tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({en, done} !== 2'b10) begin
      fails++; $display("[TB] FAIL settle_first_run: got %b, expected 10", {en, done});
    end
    tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({en, done} !== 2'b10) begin
      fails++; $display("[TB] FAIL settle_guard_holds: got %b, expected 10", {en, done});
    end
    tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({en, done} !== 2'b01) begin
      fails++; $display("[TB] FAIL done_second_run: got %b, expected 01", {en, done});
    end
    idle();
  endtask

  task automatic test_stop_beats_zero();
    key(4'd1);
    tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(); idle();
    tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({en, done} !== 2'b00) begin
      fails++; $display("[TB] FAIL stop_beats_zero: got %b, expected 00", {en, done});
    end
    tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({en, done, loadn} !== 3'b101) begin
      fails++; $display("[TB] FAIL resume_with_zero: got %b, expected 101", {en, done, loadn});
    end
    tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({en, done} !== 2'b01) begin
      fails++; $display("[TB] FAIL done_after_resume: got %b, expected 01", {en, done});
    end
    idle();
  endtask

  task automatic test_async_reset();
    key(4'd3);
    tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle();
    checks++;
    if (en !== 1'b1) begin
      fails++; $display("[TB] FAIL run_before_reset: got %b, expected 1", en);
    end
    #3 clrn = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== {16'h0000, 5'b10000}) begin
      fails++; $display("[TB] FAIL async_reset: got %h, expected %h", dut_vec(), {16'h0000, 5'b10000});
    end
    #1 clrn = 1'b0;
    model_reset();
    idle();
    checks++;
    if (dut_vec() !== {16'h0000, 5'b10000}) begin
      fails++; $display("[TB] FAIL post_reset_idle: got %h, expected %h", dut_vec(), {16'h0000, 5'b10000});
    end
  endtask

  task automatic test_clear_wins();
    key(4'd4); key(4'd2);
    tick(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (dut_digits() !== 16'h0000 || loadn !== 1'b1) begin
      fails++; $display("[TB] FAIL clear_wins: got %h loadn=%b, expected 0000 loadn=1", dut_digits(), loadn);
    end
    idle();
    checks++;
    if ({loadn, en} !== 2'b10) begin
      fails++; $display("[TB] FAIL clear_wins_no_load: got %b, expected 10", {loadn, en});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      logic       kv, st, sc, tz;
      logic [3:0] kc;
      kv = ($urandom_range(0, 99) < 45);
      kc = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      st = ($urandom_range(0, 99) < 12);
      sc = ($urandom_range(0, 99) < 4);
      tz = ($urandom_range(0, 99) < 20);
      tick(kv, kc, st, sc, tz);
      checks++;
      if (dut_vec() !== model_vec()) begin
        fails++; $display("[TB] FAIL random_cycle %0d: got %h, expected %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_entry_and_load();
    test_key_limit();
    test_bad_secs();
    test_empty_start();
    test_pause_resume();
    test_settle_guard();
    test_stop_beats_zero();
    test_async_reset();
    test_clear_wins();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
